// File: rtl/step_pulse_gen_pkg.sv
// Shared FSM state encoding and counter sizing for the step pulse generator.
package step_pulse_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_PRESSED,
    ST_REPEAT,
    ST_DB_RELEASE
  } state_e;

  // Width that holds 0..max-1 for the largest of the three cycle parameters.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; reset clears both stages.
// Latency: 2 cycles; backpressure: none.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced pushbutton to one-cycle step pulses, with optional hold-to-repeat.
// Latency: step 2+DEBOUNCE_CYCLES cycles after first high sample; backpressure: none.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 5000000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic step,
  output logic btn_level,
  output logic repeating
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("step_pulse_gen: DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must all be >= 2");
  end

  logic sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync)
  );

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          step_d, step_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    step_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sync) state_d = ST_DB_PRESS;
      end
      ST_DB_PRESS: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          step_d  = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!sync) begin
          state_d = ST_DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Hold the count at its last value so repeat_en can arm later without wrap.
          cnt_d = cnt_q;
          if (repeat_en) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            step_d  = 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (!sync) begin
          state_d = ST_DB_RELEASE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        if (sync) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign step      = step_q;
  assign btn_level = (state_q == ST_PRESSED) || (state_q == ST_REPEAT) ||
                     (state_q == ST_DB_RELEASE);
  assign repeating = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen with small parameters; step timing is checked against a queue of expected edges.
module tb_step_pulse_gen;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst, btn_in, repeat_en;
  logic step, btn_level, repeating;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int step_count = 0;
  bit prev_step = 1'b0;
  int sb_q[$];

  typedef struct {
    int hi;
    int lo;
    int reps;
    bit rep;
    int exp_steps;
    bit exp_lvl;
    bit exp_rpt;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .step      (step),
    .btn_level (btn_level),
    .repeating (repeating)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Advance one cycle and score any step pulse against the expected-edge queue.
  task automatic cyc();
    @(negedge clk);
    if (step === 1'b1) begin
      step_count++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL step_unexpected: step after edge %0d, none expected", edge_cnt);
      end else begin
        check("step_time", edge_cnt, sb_q.pop_front());
      end
      check("step_not_back_to_back", {31'd0, prev_step}, 32'd0);
    end
    prev_step = (step === 1'b1);
  endtask

  // Press first sampled at edge k, held for len samples: steps need sync=1 at the FSM, i.e. edge <= k+len+1.
  task automatic push_press(input int k, input int len, input bit rep);
    if (k + D + 2 <= k + len + 1) sb_q.push_back(k + D + 2);
    if (rep)
      for (int e = k + D + 2 + H; e <= k + len + 1; e += R) sb_q.push_back(e);
  endtask

  int k, base, e0;

  initial begin
    vecs[0] = '{12, 10, 1, 1'b0, 1,  1'b1, 1'b0};
    vecs[1] = '{2,  2,  5, 1'b0, 0,  1'b0, 1'b0};
    vecs[2] = '{40, 10, 1, 1'b1, 10, 1'b1, 1'b1};
    vecs[3] = '{3,  6,  3, 1'b0, 0,  1'b0, 1'b0};
    vecs[4] = '{4,  8,  1, 1'b0, 0,  1'b0, 1'b0};
    vecs[5] = '{5,  8,  1, 1'b0, 1,  1'b0, 1'b0};
    vecs[6] = '{17, 8,  1, 1'b1, 2,  1'b1, 1'b1};
    vecs[7] = '{15, 8,  1, 1'b1, 2,  1'b1, 1'b0};
    vecs[8] = '{14, 8,  1, 1'b1, 1,  1'b1, 1'b0};

    rst = 1'b1;
    btn_in = 1'b0;
    repeat_en = 1'b0;
    repeat (3) cyc();
    check("reset_step", {31'd0, step}, 32'd0);
    check("reset_btn_level", {31'd0, btn_level}, 32'd0);
    check("reset_repeating", {31'd0, repeating}, 32'd0);
    rst = 1'b0;
    repeat (5) cyc();

    for (int i = 0; i < NV; i++) begin
      base = step_count;
      repeat_en = vecs[i].rep;
      for (int r = 0; r < vecs[i].reps; r++) begin
        btn_in = 1'b1;
        k = edge_cnt + 1;
        push_press(k, vecs[i].hi, vecs[i].rep);
        repeat (vecs[i].hi) cyc();
        check($sformatf("vec%0d_level_held", i), {31'd0, btn_level}, {31'd0, vecs[i].exp_lvl});
        check($sformatf("vec%0d_repeating_held", i), {31'd0, repeating}, {31'd0, vecs[i].exp_rpt});
        btn_in = 1'b0;
        repeat (vecs[i].lo) cyc();
      end
      repeat (12) cyc();
      check($sformatf("vec%0d_step_count", i), step_count - base, vecs[i].exp_steps);
      check($sformatf("vec%0d_level_released", i), {31'd0, btn_level}, 32'd0);
      check($sformatf("vec%0d_pending_steps", i), sb_q.size(), 32'd0);
    end

    // Release bounce shorter than debounce: level stays high and the hold count restarts.
    repeat_en = 1'b1;
    btn_in = 1'b1;
    k = edge_cnt + 1;
    sb_q.push_back(k + D + 2);
    sb_q.push_back(k + 12 + H);
    repeat (8) cyc();
    btn_in = 1'b0;
    repeat (2) begin
      cyc();
      check("bounce_level_low_phase", {31'd0, btn_level}, 32'd1);
    end
    btn_in = 1'b1;
    repeat (12) begin
      cyc();
      check("bounce_level_high_phase", {31'd0, btn_level}, 32'd1);
    end
    check("bounce_hold_restarted", {31'd0, repeating}, 32'd0);
    btn_in = 1'b0;
    repeat (14) cyc();
    check("bounce_pending_steps", sb_q.size(), 32'd0);
    check("bounce_level_released", {31'd0, btn_level}, 32'd0);

    // Reset while repeating with the button held: press is discarded and restarts from scratch.
    repeat_en = 1'b1;
    btn_in = 1'b1;
    k = edge_cnt + 1;
    sb_q.push_back(k + D + 2);
    sb_q.push_back(k + D + 2 + H);
    sb_q.push_back(k + D + 2 + H + R);
    repeat (21) cyc();
    check("pre_reset_repeating", {31'd0, repeating}, 32'd1);
    rst = 1'b1;
    cyc();
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_btn_level", {31'd0, btn_level}, 32'd0);
    check("rst_repeating", {31'd0, repeating}, 32'd0);
    cyc();
    rst = 1'b0;
    e0 = edge_cnt + 1;
    sb_q.push_back(e0 + D + 2);
    repeat (8) cyc();
    check("post_reset_level", {31'd0, btn_level}, 32'd1);
    btn_in = 1'b0;
    repeat_en = 1'b0;
    repeat (14) cyc();
    check("post_reset_pending_steps", sb_q.size(), 32'd0);
    check("post_reset_level_released", {31'd0, btn_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000: cycles the synchronized button must be stable before a press or release is accepted.
REQ-002 SHALL have parameter HOLD_CYCLES, default 5000000: cycles of accepted press before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 2500000: auto-repeat step interval in cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port btn_in, input, 1 bit: raw asynchronous pushbutton, high = pressed.
REQ-007 SHALL have port repeat_en, input, 1 bit: enables auto-repeat while held.
REQ-008 SHALL have port step, output, 1 bit: one-cycle advance pulse to the downstream letter sequencer.
REQ-009 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-010 SHALL have port repeating, output, 1 bit: high while in REPEAT state.

Function
REQ-011 SHALL pass btn_in through a two-flop synchronizer; only its output (sync) drives the FSM.
REQ-012 SHALL implement FSM states IDLE, DB_PRESS, PRESSED, REPEAT, DB_RELEASE with one shared counter cnt, cleared on every state change.
REQ-013 IDLE: sync=1 -> DB_PRESS.
REQ-014 DB_PRESS: sync=0 -> IDLE, no step; sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED with step=1; else cnt+1.
REQ-015 PRESSED: sync=0 -> DB_RELEASE; repeat_en=1 and cnt==HOLD_CYCLES-1 -> REPEAT with step=1; else cnt+1, saturating at HOLD_CYCLES-1 while repeat_en=0.
REQ-016 REPEAT: sync=0 -> DB_RELEASE; repeat_en=0 -> PRESSED, cnt=0, no step; cnt==REPEAT_CYCLES-1 -> cnt=0, step=1; else cnt+1.
REQ-017 DB_RELEASE: sync=1 -> PRESSED, cnt=0, no step; sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-018 step SHALL be registered, high for exactly one cycle per event, never on consecutive cycles.
REQ-019 Latency: btn_in first sampled high at edge k and held -> step high in the cycle following edge k+DEBOUNCE_CYCLES+2.
REQ-020 btn_level SHALL be 1 in PRESSED, REPEAT, DB_RELEASE, else 0; repeating SHALL be 1 only in REPEAT.
REQ-021 Bounce shorter than DEBOUNCE_CYCLES, on press or release, SHALL produce no step and no btn_level change.
REQ-022 cnt width SHALL be $clog2 of the largest of the three parameters; no wrap-around may occur before a compare match.
REQ-023 Parameter values below 2 are illegal; an elaboration-time check SHALL flag them.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, cnt=0, synchronizer flops=0, step=0, btn_level=0, repeating=0; rst has priority over all other inputs.
REQ-025 Reset mid-press SHALL discard the press; a button still held after reset is treated as a new press and produces a new step after full debounce.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the counter-width function/constant.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, with reset clearing both flops.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-028 Clean press sampled at edge 10, held 12 cycles, repeat_en=0 -> single step in the cycle after edge 16; btn_level 1 from then on; no further steps.
REQ-029 btn_in high 2 cycles then low, repeated 5 times -> zero steps, btn_level stays 0.
REQ-030 Press held 40 cycles with repeat_en=1 -> step at debounce, step 10 cycles later, then one every 3 cycles; repeating=1 after the first repeat step.
REQ-031 Release bounce of 2 cycles low then high while PRESSED -> no step, btn_level stays 1, hold count restarts.
REQ-032 rst asserted 2 cycles while in REPEAT with btn_in held -> all outputs 0 the cycle after the reset edge; step again 6 cycles after rst deasserts.
